// File: rtl/dec_pkg.sv
// Shared constants, types and GF(2^m) helpers for the RS syndrome stage.
// No ports. Provides the code geometry (beats per codeword, pad lanes,
// beat counter width), the symbol type and two GF functions. gf_pow is
// used to fold every multiplier constant at elaboration time.
package dec_pkg;

  localparam int EGF_ORDER   = 8;
  localparam logic [EGF_ORDER:0] EGF_POLY = 9'h11D;
  localparam int ENC_SYM_NUM = 4;
  localparam int RS_COD_LEN  = 255;
  localparam int RS_PAR_LEN  = 16;
  localparam int RS_FCR      = 0;

  localparam int GF_MAX_EXP = (1 << EGF_ORDER) - 1;
  localparam int DEC_BEATS  = (RS_COD_LEN + ENC_SYM_NUM - 1) / ENC_SYM_NUM;
  localparam int DEC_PAD    = DEC_BEATS * ENC_SYM_NUM - RS_COD_LEN;
  localparam int DEC_CNT_W  = (DEC_BEATS > 1) ? $clog2(DEC_BEATS) : 1;
  localparam int LANE_W     = ENC_SYM_NUM * EGF_ORDER;
  localparam int SYN_W      = RS_PAR_LEN * EGF_ORDER;

  typedef logic [EGF_ORDER-1:0] sym_t;
  typedef logic [DEC_CNT_W-1:0] beat_cnt_t;

  // Shift-and-add GF(2^m) multiply, reducing by EGF_POLY on each shift.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t prod;
    sym_t sh;
    prod = {EGF_ORDER{1'b0}};
    sh   = a;
    for (int i = 0; i < EGF_ORDER; i++) begin
      if (b[i]) prod = prod ^ sh;
      else      prod = prod;
      if (sh[EGF_ORDER-1]) sh = (sh << 1) ^ EGF_POLY[EGF_ORDER-1:0];
      else                 sh = sh << 1;
    end
    return prod;
  endfunction

  // alpha^e by square-and-multiply; the exponent is reduced mod 2^m-1 first.
  function automatic sym_t gf_pow(input int e);
    int   ee;
    sym_t res;
    sym_t base;
    ee   = e % GF_MAX_EXP;
    res  = {{(EGF_ORDER-1){1'b0}}, 1'b1};
    base = {{(EGF_ORDER-2){1'b0}}, 2'b10};
    for (int i = 0; i < 16; i++) begin
      if (((ee >> i) & 1) == 1) res = gf_mul(res, base);
      else                      res = res;
      base = gf_mul(base, base);
    end
    return res;
  endfunction

endpackage

// File: rtl/dec_syndrome_if.sv
// Handshake bundle between the codeword source, the syndrome stage and the
// key-equation solver.
//   in_valid/in_ready/in_data     : received symbols, one beat per transfer
//   out_valid/out_ready           : completed syndrome result handshake
//   syn_data/syn_err              : syndrome vector (S_0 at LSBs), nonzero flag
// master = source/sink side, slave = the syndrome stage.
interface dec_syndrome_if;
  import dec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SYN_W-1:0]  syn_data;
  logic              syn_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, syn_data, syn_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, syn_data, syn_err
  );

endinterface

// File: rtl/dec_syn_cell.sv
// One syndrome accumulator for root alpha^(FCR+J), parallel Horner form.
//   clk, rst     : clock, asynchronous active-high reset
//   beat_accept  : a beat is consumed this cycle
//   beat_first   : current beat is beat 0 (accumulator contribution ignored)
//   lanes        : pad-masked symbols, lane 0 = lowest degree
//   acc_next     : updated accumulator value for this beat (combinational)
module dec_syn_cell
  import dec_pkg::*;
#(
  parameter int J = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_accept,
  input  logic              beat_first,
  input  logic [LANE_W-1:0] lanes,
  output sym_t              acc_next
);

  // Advancing the accumulator by one beat shifts it up N degrees.
  localparam sym_t STEP_C = gf_pow((RS_FCR + J) * ENC_SYM_NUM);

  sym_t acc_r;
  sym_t lane_prod_s [ENC_SYM_NUM];
  sym_t lane_sum_s;

  for (genvar k = 0; k < ENC_SYM_NUM; k++) begin : g_lane
    localparam sym_t LANE_C = gf_pow((RS_FCR + J) * k);
    assign lane_prod_s[k] = gf_mul(lanes[k*EGF_ORDER +: EGF_ORDER], LANE_C);
  end

  // XOR-sum of lane products plus the scaled accumulator; beat 0 starts fresh.
  always_comb begin
    lane_sum_s = {EGF_ORDER{1'b0}};
    for (int k = 0; k < ENC_SYM_NUM; k++) begin
      lane_sum_s = lane_sum_s ^ lane_prod_s[k];
    end
    if (beat_first) acc_next = lane_sum_s;
    else            acc_next = gf_mul(acc_r, STEP_C) ^ lane_sum_s;
  end

  // Accumulator register, advanced only on an accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              acc_r <= {EGF_ORDER{1'b0}};
    else if (beat_accept) acc_r <= acc_next;
    else                  acc_r <= acc_r;
  end

endmodule

// File: rtl/dec_syndrome.sv
// RS decoder input stage: accumulates RS_PAR_LEN syndromes over a codeword
// streamed ENC_SYM_NUM symbols per beat and hands the result downstream.
//   clk  : clock
//   rst  : asynchronous active-high reset (drops any partial codeword)
//   bus  : dec_syndrome_if.slave -- input beat handshake, result handshake,
//          syn_data (S_j in lane j) and syn_err (any S_j nonzero)
module dec_syndrome (
  input  logic                 clk,
  input  logic                 rst,
  dec_syndrome_if.slave        bus
);
  import dec_pkg::*;

  beat_cnt_t         beat_cnt_r;
  logic              beat_first_s;
  logic              beat_last_s;
  logic              accept_s;
  logic              in_ready_s;
  logic [LANE_W-1:0] lanes_s;
  sym_t              syn_next_s [RS_PAR_LEN];
  logic [SYN_W-1:0]  syn_next_flat_s;
  logic              out_valid_r;
  logic [SYN_W-1:0]  syn_data_r;
  logic              syn_err_r;

  // A pending unconsumed result blocks input so it cannot be overwritten.
  assign in_ready_s   = ~(out_valid_r & ~bus.out_ready);
  assign accept_s     = bus.in_valid & in_ready_s;
  assign beat_first_s = (beat_cnt_r == beat_cnt_t'(0));
  assign beat_last_s  = (beat_cnt_r == beat_cnt_t'(DEC_BEATS - 1));

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.syn_data  = syn_data_r;
  assign bus.syn_err   = syn_err_r;

  // The codeword is end-aligned, so the top lanes of beat 0 carry no symbols.
  always_comb begin
    lanes_s = bus.in_data;
    for (int k = 0; k < ENC_SYM_NUM; k++) begin
      if (beat_first_s && (k >= ENC_SYM_NUM - DEC_PAD))
        lanes_s[k*EGF_ORDER +: EGF_ORDER] = {EGF_ORDER{1'b0}};
      else
        lanes_s[k*EGF_ORDER +: EGF_ORDER] = bus.in_data[k*EGF_ORDER +: EGF_ORDER];
    end
  end

  for (genvar j = 0; j < RS_PAR_LEN; j++) begin : g_cell
    dec_syn_cell #(.J(j)) u_cell (
      .clk         (clk),
      .rst         (rst),
      .beat_accept (accept_s),
      .beat_first  (beat_first_s),
      .lanes       (lanes_s),
      .acc_next    (syn_next_s[j])
    );
  end

  // Pack the per-root accumulator outputs into the lane layout of syn_data.
  always_comb begin
    syn_next_flat_s = {SYN_W{1'b0}};
    for (int j = 0; j < RS_PAR_LEN; j++) begin
      syn_next_flat_s[j*EGF_ORDER +: EGF_ORDER] = syn_next_s[j];
    end
  end

  // Beat position within the codeword; wraps after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               beat_cnt_r <= beat_cnt_t'(0);
    else if (!accept_s)    beat_cnt_r <= beat_cnt_r;
    else if (beat_last_s)  beat_cnt_r <= beat_cnt_t'(0);
    else                   beat_cnt_r <= beat_cnt_r + beat_cnt_t'(1);
  end

  // Result register: a new last beat wins over a same-cycle consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      syn_data_r  <= {SYN_W{1'b0}};
      syn_err_r   <= 1'b0;
    end else if (accept_s && beat_last_s) begin
      out_valid_r <= 1'b1;
      syn_data_r  <= syn_next_flat_s;
      syn_err_r   <= |syn_next_flat_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_dec_syndrome.sv
// Self-checking bench for dec_syndrome. Reference syndromes come from direct
// polynomial evaluation r(alpha^(FCR+j)) over log/antilog tables; codewords
// come from a systematic RS encoder built from the generator polynomial.
module tb_dec_syndrome;
  import dec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec_syndrome_if bus ();

  dec_syndrome dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int gf_exp [512];
  int gf_log [256];
  int gen    [RS_PAR_LEN+1];
  int cw     [RS_COD_LEN];
  int pad_sym  = -1;
  int rdy_mode = 0;
  int cyc      = 0;
  logic [SYN_W-1:0] exp_q [$];
  logic [SYN_W-1:0] last_syn = '0;

  // monitor state
  int               tb_beat  = 0;
  bit               lat_pend = 1'b0;
  bit               hold_vld = 1'b0;
  logic [SYN_W:0]   hold_val = '0;

  task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gf_exp[gf_log[a] + gf_log[b]];
  endfunction

  function automatic logic [SYN_W-1:0] model_syn();
    logic [SYN_W-1:0] res;
    int s;
    res = '0;
    for (int j = 0; j < RS_PAR_LEN; j++) begin
      s = 0;
      for (int i = 0; i < RS_COD_LEN; i++)
        s = s ^ gmul(cw[i], gf_exp[((RS_FCR + j) * i) % 255]);
      res[j*8 +: 8] = s[7:0];
    end
    return res;
  endfunction

  // cw[254..16] hold the message; fill cw[15..0] with parity.
  task automatic encode();
    int r [RS_PAR_LEN];
    int fb;
    for (int i = 0; i < RS_PAR_LEN; i++) r[i] = 0;
    for (int d = RS_COD_LEN - 1; d >= RS_PAR_LEN; d--) begin
      fb = cw[d] ^ r[RS_PAR_LEN-1];
      for (int i = RS_PAR_LEN - 1; i > 0; i--) r[i] = r[i-1] ^ gmul(fb, gen[i]);
      r[0] = gmul(fb, gen[0]);
    end
    for (int i = 0; i < RS_PAR_LEN; i++) cw[i] = r[i];
  endtask

  task automatic clear_cw();
    for (int i = 0; i < RS_COD_LEN; i++) cw[i] = 0;
  endtask

  task automatic random_cw();
    for (int i = 0; i < RS_COD_LEN; i++) cw[i] = int'($urandom_range(0, 255));
  endtask

  function automatic logic [31:0] beat_data(input int b);
    logic [31:0] d;
    int deg;
    int v;
    for (int k = 0; k < 4; k++) begin
      deg = (DEC_BEATS - 1 - b) * 4 + k;
      if (deg < RS_COD_LEN) v = cw[deg];
      else if (pad_sym >= 0) v = pad_sym;
      else v = int'($urandom_range(0, 255));
      d[k*8 +: 8] = v[7:0];
    end
    return d;
  endfunction

  task automatic send_beat(input logic [31:0] d);
    int n;
    logic got;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 2000) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      n++;
    end
    if (!got) check_val("beat_timeout", 0, 1);
    #1;
  endtask

  task automatic send_frame(input int gap_pct, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        @(posedge clk);
        #1;
      end
      send_beat(beat_data(b));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Result monitor: latency, hold stability and scoreboard comparison.
  always @(negedge clk) begin
    if (rst) begin
      tb_beat  = 0;
      lat_pend = 1'b0;
      hold_vld = 1'b0;
    end else begin
      if (lat_pend) check_val("latency", bus.out_valid, 1);
      lat_pend = 1'b0;
      if (hold_vld) begin
        check_val("hold_valid", bus.out_valid, 1);
        check_val("hold_data", {bus.syn_err, bus.syn_data}, hold_val);
      end
      if (bus.in_valid && bus.in_ready) begin
        if (tb_beat == DEC_BEATS - 1) lat_pend = 1'b1;
        tb_beat = (tb_beat + 1) % DEC_BEATS;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_result", 1, 0);
        end else begin
          logic [SYN_W-1:0] e;
          e = exp_q.pop_front();
          check_val("syn_data", bus.syn_data, e);
          check_val("syn_err", bus.syn_err, (e != '0));
          last_syn = bus.syn_data;
        end
      end
      hold_vld = bus.out_valid && !bus.out_ready;
      hold_val = {bus.syn_err, bus.syn_data};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int x;
    logic [SYN_W-1:0] exp_b;
    int c0;
    int root;

    // GF tables and generator polynomial
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gf_exp[i] = x;
      gf_exp[i+255] = x;
      gf_log[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    gf_exp[510] = gf_exp[0];
    gf_exp[511] = gf_exp[1];
    gf_log[0] = 0;
    for (int i = 0; i <= RS_PAR_LEN; i++) gen[i] = 0;
    gen[0] = 1;
    for (int j = 0; j < RS_PAR_LEN; j++) begin
      root = gf_exp[(RS_FCR + j) % 255];
      for (int i = j + 1; i > 0; i--) gen[i] = gen[i-1] ^ gmul(gen[i], root);
      gen[0] = gmul(gen[0], root);
    end

    // reset
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_syn_err", bus.syn_err, 0);
    check_val("rst_syn_data", bus.syn_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("in_ready_after_rst", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // 1: all-zero codeword, one-cycle result pulse
    clear_cw();
    exp_q.push_back(model_syn());
    send_frame(0, DEC_BEATS);
    @(negedge clk);
    @(negedge clk);
    check_val("t1_pulse", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // 2: encoded message 1..239, three codewords back to back
    clear_cw();
    for (int m = 0; m < 239; m++) cw[RS_COD_LEN - 1 - m] = m + 1;
    encode();
    c0 = cyc;
    repeat (3) begin
      exp_q.push_back('0);
      send_frame(0, DEC_BEATS);
    end
    check_val("t2_no_gap", cyc - c0, 3 * DEC_BEATS);
    wait_drain();

    // 3: single error 0x05 at degree 0
    clear_cw();
    cw[0] = 5;
    exp_q.push_back({RS_PAR_LEN{8'h05}});
    send_frame(0, DEC_BEATS);
    wait_drain();

    // 4: 0x01 at degree 1
    clear_cw();
    cw[1] = 1;
    exp_q.push_back(model_syn());
    send_frame(0, DEC_BEATS);
    wait_drain();
    check_val("t4_s0", last_syn[0 +: 8], 8'h01);
    check_val("t4_s1", last_syn[8 +: 8], 8'h02);
    check_val("t4_s2", last_syn[16 +: 8], 8'h04);
    check_val("t4_s8", last_syn[64 +: 8], 8'h1D);

    // 5a: pad lane carries 0xFF, must be masked
    clear_cw();
    pad_sym = 255;
    exp_q.push_back('0);
    send_frame(0, DEC_BEATS);
    pad_sym = -1;
    wait_drain();

    // 5b: backpressure with the next codeword's beat 0 waiting
    random_cw();
    rdy_mode = 2;
    exp_q.push_back(model_syn());
    send_frame(0, DEC_BEATS);
    random_cw();
    exp_b = model_syn();
    bus.in_valid = 1'b1;
    bus.in_data  = beat_data(0);
    repeat (10) begin
      @(negedge clk);
      check_val("t5_stall_ready", bus.in_ready, 0);
    end
    rdy_mode = 0;
    @(posedge clk);
    #1;
    exp_q.push_back(exp_b);
    send_frame(0, DEC_BEATS);
    wait_drain();

    // random codewords with random gaps and backpressure
    repeat (6) begin
      rdy_mode = 1;
      if ($urandom_range(0, 1) == 1) begin
        random_cw();
      end else begin
        random_cw();
        encode();
        repeat (int'($urandom_range(1, 3))) cw[$urandom_range(0, 254)] ^= int'($urandom_range(1, 255));
      end
      exp_q.push_back(model_syn());
      send_frame(25, DEC_BEATS);
    end
    rdy_mode = 0;
    wait_drain();

    // 6: reset after beat 30, then a clean codeword
    random_cw();
    send_frame(0, 31);
    #1 rst = 1'b1;
    #1;
    check_val("t6_out_valid", bus.out_valid, 0);
    check_val("t6_syn_err", bus.syn_err, 0);
    check_val("t6_syn_data", bus.syn_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    random_cw();
    encode();
    exp_q.push_back(model_syn());
    send_frame(0, DEC_BEATS);
    wait_drain();
    check_val("t6_clean_zero", last_syn, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
